// File: rtl/change_dispenser_if.sv
// change_dispenser_if: request, refill, coin-pulse and inventory signals of the change dispenser.
interface change_dispenser_if #(parameter int INV_W = 4);
    logic             req;
    logic [3:0]       amount;
    logic             refill_5;
    logic             refill_10;
    logic             busy;
    logic             coin_5;
    logic             coin_10;
    logic             done;
    logic             short;
    logic [3:0]       remaining;
    logic [INV_W-1:0] inv_5;
    logic [INV_W-1:0] inv_10;
    modport master (
        output req, amount, refill_5, refill_10,
        input  busy, coin_5, coin_10, done, short, remaining, inv_5, inv_10
    );
    modport slave (
        input  req, amount, refill_5, refill_10,
        output busy, coin_5, coin_10, done, short, remaining, inv_5, inv_10
    );
endinterface

// File: rtl/change_dispenser.sv
// change_dispenser: greedy 10/5 coin payout from two tracked hoppers with spaced coin pulses.
// CHANGE_EXACT_CHECK_EN: refuse up front any request the hoppers cannot pay exactly.
module change_dispenser #(
    parameter int INV_W     = 4,
    parameter int INIT_5    = 8,
    parameter int INIT_10   = 8,
    parameter int PULSE_GAP = 2
) (
    input logic               clk,
    input logic               rst,
    change_dispenser_if.slave bus
);
    typedef enum logic [2:0] {IDLE, CHECK, EJECT, GAP, FINISH} state_t;
    localparam int GW = PULSE_GAP > 1 ? $clog2(PULSE_GAP) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(PULSE_GAP - 1);
    localparam logic [INV_W-1:0] INV_MAX = '1;
    state_t           state_q, state_d;
    logic [3:0]       rem_q, rem_d;
    logic [INV_W-1:0] inv5_q, inv5_d, inv10_q, inv10_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic             sel10_q, sel10_d;
    logic             ok_q, ok_d;
    logic             dec5, dec10;
    logic             infeasible;

`ifdef CHANGE_EXACT_CHECK_EN
    localparam int EW = INV_W + 5;
    logic          first_q, first_d;
    logic [EW-1:0] half, n10;
    // Only the first CHECK of a request judges feasibility; later CHECKs run greedy.
    always_comb begin
        half       = EW'(rem_q >> 1);
        n10        = EW'(inv10_q) < half ? EW'(inv10_q) : half;
        infeasible = first_q && (EW'(rem_q) > EW'(inv5_q) + (n10 << 1));
        first_d    = (state_q == IDLE && bus.req) ? 1'b1 : (state_q == CHECK) ? 1'b0 : first_q;
    end
    always_ff @(posedge clk) begin
        if (rst) first_q <= 1'b0;
        else     first_q <= first_d;
    end
`else
    assign infeasible = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        gap_d   = gap_q;
        sel10_d = sel10_q;
        ok_d    = ok_q;
        dec5    = 1'b0;
        dec10   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    rem_d   = bus.amount;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (rem_q == 4'd0) begin
                    ok_d    = 1'b1;
                    state_d = FINISH;
                end else if (infeasible) begin
                    ok_d    = 1'b0;
                    state_d = FINISH;
                end else if (rem_q >= 4'd2 && inv10_q != '0) begin
                    sel10_d = 1'b1;
                    state_d = EJECT;
                end else if (inv5_q != '0) begin
                    sel10_d = 1'b0;
                    state_d = EJECT;
                end else begin
                    ok_d    = 1'b0;
                    state_d = FINISH;
                end
            end
            EJECT: begin
                dec10   = sel10_q;
                dec5    = !sel10_q;
                rem_d   = rem_q - (sel10_q ? 4'd2 : 4'd1);
                gap_d   = '0;
                state_d = GAP;
            end
            GAP: begin
                gap_d   = gap_q + 1'b1;
                state_d = gap_q == GAP_LAST ? CHECK : GAP;
            end
            default: state_d = IDLE;
        endcase
        // A refill coinciding with an eject on the same hopper cancels out.
        inv5_d  = (bus.refill_5 && !dec5 && inv5_q != INV_MAX) ? inv5_q + 1'b1 :
                  (dec5 && !bus.refill_5) ? inv5_q - 1'b1 : inv5_q;
        inv10_d = (bus.refill_10 && !dec10 && inv10_q != INV_MAX) ? inv10_q + 1'b1 :
                  (dec10 && !bus.refill_10) ? inv10_q - 1'b1 : inv10_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            gap_q   <= '0;
            sel10_q <= 1'b0;
            ok_q    <= 1'b0;
            inv5_q  <= INV_W'(INIT_5);
            inv10_q <= INV_W'(INIT_10);
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            gap_q   <= gap_d;
            sel10_q <= sel10_d;
            ok_q    <= ok_d;
            inv5_q  <= inv5_d;
            inv10_q <= inv10_d;
        end
    end

    assign bus.busy      = state_q != IDLE;
    assign bus.coin_10   = state_q == EJECT && sel10_q;
    assign bus.coin_5    = state_q == EJECT && !sel10_q;
    assign bus.done      = state_q == FINISH && ok_q;
    assign bus.short     = state_q == FINISH && !ok_q;
    assign bus.remaining = state_q == FINISH ? rem_q : 4'd0;
    assign bus.inv_5     = inv5_q;
    assign bus.inv_10    = inv10_q;
endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: directed and randomized checks of change_dispenser against a payout model.
module tb_change_dispenser;
    localparam int INV_W = 4, INIT_5 = 8, INIT_10 = 8, PG = 2;
    localparam int MAXI = (1 << INV_W) - 1;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    change_dispenser_if #(.INV_W(INV_W)) bus ();
    change_dispenser #(.INV_W(INV_W), .INIT_5(INIT_5), .INIT_10(INIT_10), .PULSE_GAP(PG))
        dut (.clk(clk), .rst(rst), .bus(bus));
    int total = 0, bad = 0;
    int m5, m10;
    int ec[$];
    int oc[$];
    int ot[$];
    int ofin, odone, oshort, orem, obusy_drop, obusy_after;

    task automatic do_reset;
        bus.req = 1'b0; bus.amount = 4'd0; bus.refill_5 = 1'b0; bus.refill_10 = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        m5 = INIT_5; m10 = INIT_10;
    endtask

    // Issue one request and record every coin pulse (type, cycle after acceptance) up to FINISH.
    task automatic run_req(input int amt, input int mode);
        @(posedge clk); #1;
        bus.req = 1'b1; bus.amount = 4'(amt);
        @(posedge clk); #1;
        oc.delete(); ot.delete();
        ofin = -1; odone = 0; oshort = 0; orem = -1; obusy_drop = 0;
        for (int j = 1; j <= 300 && ofin < 0; j++) begin
            if (j > 1) begin @(posedge clk); #1; end
            bus.req    = mode == 2 ? 1'b1 : mode == 1 ? 1'($urandom) : 1'b0;
            bus.amount = mode == 2 ? 4'd5 : 4'($urandom);
            if (bus.coin_10) begin oc.push_back(10); ot.push_back(j); end
            if (bus.coin_5) begin oc.push_back(5); ot.push_back(j); end
            if (!bus.busy) obusy_drop++;
            if (bus.done || bus.short) begin
                ofin = j; odone = bus.done; oshort = bus.short; orem = bus.remaining;
            end
        end
        bus.req = 1'b0;
        @(posedge clk); #1;
        obusy_after = bus.busy;
    endtask

    // Payout rules applied directly to the model inventories.
    task automatic model(input int amt, output int ok, output int rem);
        int r;
        r = amt;
        ec.delete();
`ifdef CHANGE_EXACT_CHECK_EN
        begin
            int n10;
            n10 = m10 < amt / 2 ? m10 : amt / 2;
            if (amt - 2 * n10 > m5) begin ok = 0; rem = amt; return; end
        end
`endif
        while (r > 0) begin
            if (r >= 2 && m10 > 0) begin ec.push_back(10); m10--; r -= 2; end
            else if (m5 > 0) begin ec.push_back(5); m5--; r--; end
            else break;
        end
        ok = r == 0 ? 1 : 0;
        rem = r;
    endtask

    task automatic test_reset;
        do_reset;
        total++; if ({bus.busy, bus.coin_5, bus.coin_10, bus.done, bus.short} !== 5'b0) begin
            bad++; $display("FAIL reset_flags got=%b exp=00000", {bus.busy, bus.coin_5, bus.coin_10, bus.done, bus.short}); end
        total++; if (bus.remaining !== 4'd0) begin bad++; $display("FAIL reset_remaining got=%0d exp=0", bus.remaining); end
        total++; if (bus.inv_5 !== 4'(INIT_5)) begin bad++; $display("FAIL reset_inv5 got=%0d exp=%0d", bus.inv_5, INIT_5); end
        total++; if (bus.inv_10 !== 4'(INIT_10)) begin bad++; $display("FAIL reset_inv10 got=%0d exp=%0d", bus.inv_10, INIT_10); end
    endtask

    task automatic test_basic;
        do_reset;
        run_req(3, 0);
        total++; if (oc.size() != 2 || oc[0] != 10 || ot[0] != 2 || oc[1] != 5 || ot[1] != 6) begin
            bad++; $display("FAIL basic_coins got_n=%0d exp 10@2,5@6", oc.size()); end
        total++; if (ofin != 10 || odone != 1 || orem != 0) begin
            bad++; $display("FAIL basic_finish got fin=%0d done=%0d rem=%0d exp fin=10 done=1 rem=0", ofin, odone, orem); end
        total++; if (bus.inv_10 !== 4'd7 || bus.inv_5 !== 4'd7) begin
            bad++; $display("FAIL basic_inv got=%0d/%0d exp=7/7", bus.inv_10, bus.inv_5); end
    endtask

    task automatic test_zero;
        do_reset;
        run_req(0, 0);
        total++; if (oc.size() != 0 || ofin != 2 || odone != 1 || oshort != 0) begin
            bad++; $display("FAIL zero_finish got coins=%0d fin=%0d done=%0d exp coins=0 fin=2 done=1", oc.size(), ofin, odone); end
        total++; if (obusy_drop != 0 || obusy_after != 0) begin
            bad++; $display("FAIL zero_busy got drop=%0d after=%0d exp 0/0", obusy_drop, obusy_after); end
    endtask

    task automatic test_short;
        do_reset;
        run_req(15, 0);
        run_req(2, 0);
        run_req(5, 0);
        total++; if (bus.inv_10 !== 4'd0 || bus.inv_5 !== 4'd2) begin
            bad++; $display("FAIL short_setup got=%0d/%0d exp=0/2", bus.inv_10, bus.inv_5); end
        run_req(3, 0);
`ifdef CHANGE_EXACT_CHECK_EN
        total++; if (oc.size() != 0 || ofin != 2 || oshort != 1 || odone != 0 || orem != 3) begin
            bad++; $display("FAIL short_exact got coins=%0d fin=%0d short=%0d rem=%0d exp 0/2/1/3", oc.size(), ofin, oshort, orem); end
        total++; if (bus.inv_5 !== 4'd2) begin bad++; $display("FAIL short_inv5 got=%0d exp=2", bus.inv_5); end
        m5 = 2; m10 = 0;
`else
        total++; if (oc.size() != 2 || oc[0] != 5 || ot[0] != 2 || oc[1] != 5 || ot[1] != 6) begin
            bad++; $display("FAIL short_coins got_n=%0d exp 5@2,5@6", oc.size()); end
        total++; if (ofin != 10 || oshort != 1 || odone != 0 || orem != 1) begin
            bad++; $display("FAIL short_finish got fin=%0d short=%0d rem=%0d exp 10/1/1", ofin, oshort, orem); end
        total++; if (bus.inv_5 !== 4'd0) begin bad++; $display("FAIL short_inv5 got=%0d exp=0", bus.inv_5); end
        m5 = 0; m10 = 0;
`endif
    endtask

    task automatic test_refill;
        int seen;
        seen = 0;
        do_reset;
        bus.req = 1'b1; bus.amount = 4'd2;
        @(posedge clk); #1;
        bus.req = 1'b0;
        for (int j = 1; j <= 10 && seen == 0; j++) begin
            @(posedge clk); #1;
            if (bus.coin_10) begin
                seen = 1; bus.refill_10 = 1'b1;
                @(posedge clk); #1;
                bus.refill_10 = 1'b0;
            end
        end
        total++; if (seen != 1 || bus.inv_10 !== 4'd8) begin
            bad++; $display("FAIL refill_eject got seen=%0d inv10=%0d exp seen=1 inv10=8", seen, bus.inv_10); end
        for (int j = 0; j < 20 && !bus.done; j++) begin @(posedge clk); #1; end
        total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL refill_done got=%b exp=1", bus.done); end
        @(posedge clk); #1;
        bus.refill_10 = 1'b1;
        @(posedge clk); #1;
        bus.refill_10 = 1'b0;
        total++; if (bus.inv_10 !== 4'd9) begin bad++; $display("FAIL refill10_inc got=%0d exp=9", bus.inv_10); end
        bus.refill_5 = 1'b1;
        repeat (9) @(posedge clk);
        #1 bus.refill_5 = 1'b0;
        total++; if (bus.inv_5 !== 4'd15) begin bad++; $display("FAIL refill5_sat got=%0d exp=15", bus.inv_5); end
        m5 = 15; m10 = 9;
    endtask

    task automatic test_back_to_back;
        int extra;
        extra = 0;
        do_reset;
        run_req(2, 2);
        total++; if (oc.size() != 1 || oc[0] != 10 || ot[0] != 2 || ofin != 6 || odone != 1) begin
            bad++; $display("FAIL ignore_req got coins=%0d fin=%0d done=%0d exp 1/6/1", oc.size(), ofin, odone); end
        for (int j = 0; j < 8; j++) begin
            if (bus.done || bus.short || bus.coin_5 || bus.coin_10 || bus.busy) extra++;
            @(posedge clk); #1;
        end
        total++; if (extra != 0 || bus.inv_5 !== 4'd8) begin
            bad++; $display("FAIL ignore_after got extra=%0d inv5=%0d exp 0/8", extra, bus.inv_5); end
    endtask

    task automatic test_reset_mid;
        int c10;
        do_reset;
        bus.req = 1'b1; bus.amount = 4'd4;
        @(posedge clk); #1;
        bus.req = 1'b0;
        @(posedge clk); #1;
        c10 = bus.coin_10;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++; if (c10 != 1) begin bad++; $display("FAIL mid_coin got=%0d exp=1", c10); end
        total++; if ({bus.busy, bus.done, bus.short, bus.coin_5, bus.coin_10} !== 5'b0) begin
            bad++; $display("FAIL mid_abort got=%b exp=00000", {bus.busy, bus.done, bus.short, bus.coin_5, bus.coin_10}); end
        total++; if (bus.inv_5 !== 4'(INIT_5) || bus.inv_10 !== 4'(INIT_10)) begin
            bad++; $display("FAIL mid_inv got=%0d/%0d exp=%0d/%0d", bus.inv_10, bus.inv_5, INIT_10, INIT_5); end
        m5 = INIT_5; m10 = INIT_10;
    endtask

    task automatic test_random;
        int amt, eok, erem, seq_ok, efin;
        logic r5, r10;
        do_reset;
        for (int it = 0; it < 30; it++) begin
            for (int c = $urandom_range(0, 4); c > 0; c--) begin
                r5 = 1'($urandom); r10 = 1'($urandom);
                bus.refill_5 = r5; bus.refill_10 = r10;
                @(posedge clk); #1;
                if (r5 && m5 < MAXI) m5++;
                if (r10 && m10 < MAXI) m10++;
            end
            bus.refill_5 = 1'b0; bus.refill_10 = 1'b0;
            amt = $urandom_range(0, 15);
            model(amt, eok, erem);
            run_req(amt, 1);
            seq_ok = oc.size() == ec.size() ? 1 : 0;
            foreach (ec[i]) if (seq_ok == 1 && (oc[i] != ec[i] || ot[i] != 2 + i * (PG + 2))) seq_ok = 0;
            efin = 2 + ec.size() * (PG + 2);
            total++; if (seq_ok != 1) begin
                bad++; $display("FAIL rnd_coins it=%0d amt=%0d got_n=%0d exp_n=%0d", it, amt, oc.size(), ec.size()); end
            total++; if (ofin != efin || odone != eok || oshort != 1 - eok || orem != erem) begin
                bad++; $display("FAIL rnd_finish it=%0d got fin=%0d done=%0d short=%0d rem=%0d exp fin=%0d done=%0d rem=%0d",
                                it, ofin, odone, oshort, orem, efin, eok, erem); end
            total++; if (bus.inv_5 !== 4'(m5) || bus.inv_10 !== 4'(m10)) begin
                bad++; $display("FAIL rnd_inv it=%0d got=%0d/%0d exp=%0d/%0d", it, bus.inv_10, bus.inv_5, m10, m5); end
            total++; if (obusy_drop != 0 || obusy_after != 0) begin
                bad++; $display("FAIL rnd_busy it=%0d got drop=%0d after=%0d exp 0/0", it, obusy_drop, obusy_after); end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_zero;
        test_short;
        test_refill;
        test_back_to_back;
        test_reset_mid;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
endmodule
